// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state type and its encoding.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; chained DIGIT times to form the per-cycle digit adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per cycle over WIDTH/DIGIT cycles, LSB digit first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ps;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_s;
  logic [WIDTH-1:0] w_ps_next;
  logic             w_last;

  assign w_c[0] = r_carry;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    fa_cell u_fa (
      .a  (r_a[g]),
      .b  (r_b[g]),
      .ci (w_c[g]),
      .s  (w_s[g]),
      .co (w_c[g+1])
    );
  end

  // New digit enters at the MSB end; written as shifts so WIDTH == DIGIT needs no special slice.
  assign w_ps_next = (r_ps >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));
  assign w_last    = (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ps    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_ps    <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_c[DIGIT];
          r_ps    <= w_ps_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // w_c[DIGIT-1] is the carry into the operand MSB on the final digit.
            sum     <= w_ps_next;
            cout    <= w_c[DIGIT];
            ovf     <= w_c[DIGIT] ^ w_c[DIGIT-1];
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder in three configurations: 1/1, 8/1 and 8/4.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] cin_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [2:0] cout_v;
  logic [2:0] ovf_v;
  logic [7:0] a_v   [3];
  logic [7:0] b_v   [3];
  logic [7:0] sum_v [3];
  logic [0:0] sum1;

  int         steps [3];
  logic [7:0] last_sum  [3];
  logic       last_cout [3];
  logic       last_ovf  [3];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         k;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl [12];

  assign sum_v[0] = {7'd0, sum1};

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][0:0]), .b(b_v[0][0:0]),
    .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum1),
    .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
    .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w84 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
    .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer addition, wrapped to the configured width.
  task automatic model(input int k, input logic [7:0] av, bv, input logic cv,
                       output logic [7:0] es, output logic ec, output logic eo);
    int unsigned w, mask, t, sa, sb, ss;
    w    = (k == 0) ? 1 : 8;
    mask = (1 << w) - 1;
    t    = (32'(av) & mask) + (32'(bv) & mask) + 32'(cv);
    es   = 8'(t & mask);
    ec   = 1'((t >> w) & 1);
    sa   = (32'(av) >> (w - 1)) & 1;
    sb   = (32'(bv) >> (w - 1)) & 1;
    ss   = (t >> (w - 1)) & 1;
    eo   = (sa == sb) && (ss != sa);
  endtask

  task automatic clear_last();
    for (int i = 0; i < 3; i++) begin
      last_sum[i] = '0; last_cout[i] = 1'b0; last_ovf[i] = 1'b0;
    end
  endtask

  // Start accepted at edge 0; checks busy/done per cycle, result stability in RUN, result at done.
  task automatic run_op(input int k, input logic [7:0] av, bv, input logic cv,
                        input logic [7:0] es, input logic ec, eo,
                        input bit hold, input bit scram, input bit drop_rst);
    @(negedge clk);
    if (drop_rst) rst = 1'b0;
    chk($sformatf("k%0d idle busy", k), 32'(busy_v[k]), 32'd0);
    chk($sformatf("k%0d idle done", k), 32'(done_v[k]), 32'd0);
    start_v[k] = 1'b1; a_v[k] = av; b_v[k] = bv; cin_v[k] = cv;
    for (int cyc = 1; cyc <= steps[k] + 1; cyc++) begin
      @(negedge clk);
      if (!hold) start_v[k] = 1'b0;
      if (scram) begin
        a_v[k] = 8'($urandom); b_v[k] = 8'($urandom); cin_v[k] = 1'($urandom);
      end
      chk($sformatf("k%0d busy c%0d", k, cyc), 32'(busy_v[k]), 32'(cyc <= steps[k]));
      chk($sformatf("k%0d done c%0d", k, cyc), 32'(done_v[k]), 32'(cyc == steps[k] + 1));
      if (cyc <= steps[k]) begin
        chk($sformatf("k%0d sum hold c%0d", k, cyc), 32'(sum_v[k]), 32'(last_sum[k]));
        chk($sformatf("k%0d cout hold c%0d", k, cyc), 32'(cout_v[k]), 32'(last_cout[k]));
        chk($sformatf("k%0d ovf hold c%0d", k, cyc), 32'(ovf_v[k]), 32'(last_ovf[k]));
      end else begin
        chk($sformatf("k%0d sum %0h+%0h+%0h", k, av, bv, cv), 32'(sum_v[k]), 32'(es));
        chk($sformatf("k%0d cout %0h+%0h+%0h", k, av, bv, cv), 32'(cout_v[k]), 32'(ec));
        chk($sformatf("k%0d ovf %0h+%0h+%0h", k, av, bv, cv), 32'(ovf_v[k]), 32'(eo));
        last_sum[k] = es; last_cout[k] = ec; last_ovf[k] = eo;
      end
    end
  endtask

  initial begin
    logic [7:0] fa_s, fa_co, fa_ov, es;
    logic       ec, eo;
    int         k;
    logic [7:0] ra, rb;
    logic       rc;

    steps[0] = 1; steps[1] = 8; steps[2] = 2;
    rst = 1'b1; start_v = '0; cin_v = '0;
    for (int i = 0; i < 3; i++) begin a_v[i] = '0; b_v[i] = '0; end
    clear_last();

    tbl[0] = '{1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{1, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    tbl[3] = '{2, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    // Full-adder truth table indexed by {a,b,cin}; ovf is cin ^ cout for one bit.
    fa_s  = 8'b1001_0110;
    fa_co = 8'b1110_1000;
    fa_ov = 8'b0100_0010;
    for (int i = 0; i < 8; i++)
      tbl[4 + i] = '{0, 8'((i >> 2) & 1), 8'((i >> 1) & 1), 1'(i & 1),
                     8'(fa_s[i]), fa_co[i], fa_ov[i]};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("k%0d rst busy", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("k%0d rst done", i), 32'(done_v[i]), 32'd0);
      chk($sformatf("k%0d rst sum", i),  32'(sum_v[i]),  32'd0);
      chk($sformatf("k%0d rst cout", i), 32'(cout_v[i]), 32'd0);
      chk($sformatf("k%0d rst ovf", i),  32'(ovf_v[i]),  32'd0);
    end

    // First entry drops reset and starts in the same cycle.
    for (int i = 0; i < 12; i++)
      run_op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].co, tbl[i].ov,
             1'b0, 1'b0, i == 0);

    // start held high with operands scrambled during RUN.
    for (int i = 0; i < 2; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      model(1, ra, rb, rc, es, ec, eo);
      run_op(1, ra, rb, rc, es, ec, eo, 1'b1, 1'b1, 1'b0);
    end
    @(negedge clk);
    start_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("after hold busy %0d", i), 32'(busy_v[1]), 32'd0);
      chk($sformatf("after hold done %0d", i), 32'(done_v[1]), 32'd0);
      @(negedge clk);
    end

    // Reset in RUN cycle 3 abandons the addition.
    start_v[1] = 1'b1; a_v[1] = 8'h12; b_v[1] = 8'h34; cin_v[1] = 1'b0;
    @(posedge clk);
    @(negedge clk); start_v[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst busy before", 32'(busy_v[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_last();
    chk("midrst busy", 32'(busy_v[1]), 32'd0);
    chk("midrst done", 32'(done_v[1]), 32'd0);
    chk("midrst sum",  32'(sum_v[1]),  32'd0);
    chk("midrst cout", 32'(cout_v[1]), 32'd0);
    chk("midrst ovf",  32'(ovf_v[1]),  32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("midrst no done %0d", i), 32'(done_v[1]), 32'd0);
    end
    model(1, 8'h12, 8'h34, 1'b1, es, ec, eo);
    run_op(1, 8'h12, 8'h34, 1'b1, es, ec, eo, 1'b0, 1'b0, 1'b0);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      k  = int'($urandom_range(0, 2));
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      if (k == 0) begin ra = ra & 8'h01; rb = rb & 8'h01; end
      model(k, ra, rb, rc, es, ec, eo);
      run_op(k, ra, rb, rc, es, ec, eo, 1'b0, bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the operand and sum width in bits (at least 1).
REQ-002 The module SHALL have parameter DIGIT, default 1, meaning the bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  Reset; synchronous and active-high.
REQ-005 start  input  1  Request to begin an addition; sampled only in IDLE.
REQ-006 a  input  WIDTH  Operand A; captured on an accepted start.
REQ-007 b  input  WIDTH  Operand B; captured on an accepted start.
REQ-008 cin  input  1  Carry-in; captured on an accepted start.
REQ-009 busy  output  1  High while an addition is in progress.
REQ-010 done  output  1  Single-cycle pulse marking that the result is valid.
REQ-011 sum  output  WIDTH  Result, equal to (a+b+cin) mod 2^WIDTH.
REQ-012 cout  output  1  Unsigned carry-out of the addition.
REQ-013 ovf  output  1  Signed overflow, equal to the carry into the MSB XOR cout.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL capture a, b and cin into internal shift and carry registers, clear the step counter, and enter RUN.
REQ-016 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-017 Each RUN cycle SHALL add the DIGIT least-significant bits of the A and B shift registers plus the carry register through DIGIT chained fa_cell instances.
REQ-018 In the same RUN cycle, the block SHALL store the new carry, right-shift the operand registers by DIGIT, and shift the DIGIT result bits into the MSB end of the internal partial-sum register.
REQ-019 RUN SHALL last exactly STEPS = WIDTH/DIGIT cycles; on the last RUN edge the block SHALL load sum, cout and ovf from the final values and enter DONE.
REQ-020 DONE SHALL last one cycle, after which the block SHALL return to IDLE unconditionally.
REQ-021 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; neither SHALL be asserted in IDLE.
REQ-022 Timing: for start accepted at edge 0, busy SHALL be high in cycles 1..STEPS and done SHALL be high in cycle STEPS+1.
REQ-023 sum, cout and ovf SHALL hold their last values from DONE onward until the next completion; they SHALL NOT change during RUN.
REQ-024 start in RUN or DONE SHALL be ignored, with no queuing; a, b and cin changes during RUN SHALL NOT affect the result.
REQ-025 The step counter width SHALL be $clog2(STEPS+1); a WIDTH=DIGIT configuration SHALL complete in one RUN cycle.
REQ-026 Carry wrap-around SHALL be handled as follows: a carry out of the MSB SHALL appear only on cout, and sum SHALL wrap modulo 2^WIDTH.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and clear busy, done, sum, cout, ovf, the step counter and all internal registers to 0.
REQ-028 rst SHALL take priority over start and over any state, including a reset asserted mid-RUN: the operation is abandoned, and no done pulse is produced for it.
REQ-029 The first start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-030 Package serial_adder_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the state encoding constants.
REQ-031 Sub-module fa_cell (inputs a, b, ci; outputs s, co; purely combinational) SHALL be instantiated DIGIT times in a generate loop.
REQ-032 No other sub-modules SHALL be used; the FSM, counter and shift registers SHALL reside in serial_adder.

Verification
REQ-033 WIDTH=1, DIGIT=1, all 8 (a,b,cin) combinations -> each yields sum/cout per the full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1), with done in cycle 2.
REQ-034 WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0, with done exactly in cycle 9.
REQ-035 WIDTH=8, DIGIT=1: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; then a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
REQ-036 WIDTH=8, DIGIT=4: a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, busy for exactly 2 cycles, done in cycle 3.
REQ-037 start held high for 20 cycles with operands changed during RUN -> only operands sampled at acceptance are used, and one done per STEPS+2 cycles.
REQ-038 rst pulsed in RUN cycle 3 -> IDLE next cycle, all outputs 0, no done; a new start afterwards completes correctly.
